logic_relation_checker: RTL and testbench

- Synthesizable, parametrised successor to the team's single-pair immediate-assertion check.
- Monitors NCH independent (a,b) signal pairs over a programmable window of clock cycles.
- Evaluates a per-channel selectable relation (AND/OR/XOR/XNOR) on every cycle of the window and keeps saturating pass/fail counters, sticky fail flags and first-failure capture.
- Used as an on-chip/bench checker instead of display-only assertions; results are readable after a done pulse.

---
 rtl/logic_relation_checker_if.sv | 40 ++++
 rtl/logic_relation_checker.sv | 126 ++++++++++++
 tb/tb_logic_relation_checker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_relation_checker_if.sv
`default_nettype none
// ============================================================================
// logic_relation_checker_if : control/result bus of the relation checker
// Rev 1.0
// ============================================================================
interface logic_relation_checker_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 16,
   parameter int WIN_W = 8
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic                   start;
   logic [WIN_W-1:0]       win_len;
   logic [2*NCH-1:0]       mode;
   logic [NCH-1:0]         ch_en;
   logic [NCH-1:0]         a;
   logic [NCH-1:0]         b;
   logic                   busy;
   logic                   done;
   logic [NCH*CNT_W-1:0]   pass_cnt;
   logic [NCH*CNT_W-1:0]   fail_cnt;
   logic [NCH-1:0]         fail_sticky;
   logic                   first_fail_vld;
   logic [CH_W-1:0]        first_fail_ch;
   logic [WIN_W-1:0]       first_fail_cyc;

   modport master (
      output start, win_len, mode, ch_en, a, b,
      input  busy, done, pass_cnt, fail_cnt, fail_sticky,
             first_fail_vld, first_fail_ch, first_fail_cyc
   );

   modport slave (
      input  start, win_len, mode, ch_en, a, b,
      output busy, done, pass_cnt, fail_cnt, fail_sticky,
             first_fail_vld, first_fail_ch, first_fail_cyc
   );
endinterface
`default_nettype wire

// File: rtl/logic_relation_checker.sv
`default_nettype none
// ============================================================================
// logic_relation_checker : windowed per-channel AND/OR/XOR/XNOR checker
// Rev 1.0
// ============================================================================
module logic_relation_checker #(
   parameter int NCH   = 4,
   parameter int CNT_W = 16,
   parameter int WIN_W = 8
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   logic_relation_checker_if.slave  bus
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WIN_W-1:0]  r_win_len;
   logic [WIN_W-1:0]  r_idx;
   logic [NCH-1:0]    r_sticky;
   logic              r_ff_vld;
   logic [CH_W-1:0]   r_ff_ch;
   logic [WIN_W-1:0]  r_ff_cyc;

   logic              w_launch;
   logic              w_sample;
   logic              w_last;
   logic [NCH-1:0]    w_pass;
   logic [NCH-1:0]    w_fail;
   logic [CH_W-1:0]   w_ff_ch;

   assign w_launch = (r_state == S_IDLE) && bus.start;
   assign w_sample = (r_state == S_RUN);
   assign w_last   = (r_idx == (r_win_len - 1'b1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_next = (bus.win_len == '0) ? S_DONE : S_RUN;
         S_RUN:  if (w_last)    w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Per-channel relation evaluation and saturating counters
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic             w_rel;
      logic [CNT_W-1:0] r_pass;
      logic [CNT_W-1:0] r_fail;

      always_comb begin
         w_rel = 1'b0;
         case (bus.mode[2*gi +: 2])
            2'b00:   w_rel = bus.a[gi] & bus.b[gi];
            2'b01:   w_rel = bus.a[gi] | bus.b[gi];
            2'b10:   w_rel = bus.a[gi] ^ bus.b[gi];
            default: w_rel = ~(bus.a[gi] ^ bus.b[gi]);
         endcase
      end

      assign w_pass[gi] = bus.ch_en[gi] & w_rel;
      assign w_fail[gi] = bus.ch_en[gi] & ~w_rel;

      always_ff @(posedge clk) begin
         if (!rst_n || w_launch) begin
            r_pass <= '0;
            r_fail <= '0;
         end else if (w_sample) begin
            if (w_pass[gi] && (r_pass != '1)) r_pass <= r_pass + 1'b1;
            if (w_fail[gi] && (r_fail != '1)) r_fail <= r_fail + 1'b1;
         end
      end

      assign bus.pass_cnt[gi*CNT_W +: CNT_W] = r_pass;
      assign bus.fail_cnt[gi*CNT_W +: CNT_W] = r_fail;
   end

   // Descending scan so the lowest failing channel wins
   always_comb begin
      w_ff_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_fail[i]) w_ff_ch = CH_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || w_launch) begin
         r_win_len <= (!rst_n) ? '0 : bus.win_len;
         r_idx     <= '0;
         r_sticky  <= '0;
         r_ff_vld  <= 1'b0;
         r_ff_ch   <= '0;
         r_ff_cyc  <= '0;
      end else if (w_sample) begin
         r_idx    <= r_idx + 1'b1;
         r_sticky <= r_sticky | w_fail;
         if (!r_ff_vld && (|w_fail)) begin
            r_ff_vld <= 1'b1;
            r_ff_ch  <= w_ff_ch;
            r_ff_cyc <= r_idx;
         end
      end
   end

   assign bus.busy           = (r_state != S_IDLE);
   assign bus.done           = (r_state == S_DONE);
   assign bus.fail_sticky    = r_sticky;
   assign bus.first_fail_vld = r_ff_vld;
   assign bus.first_fail_ch  = r_ff_ch;
   assign bus.first_fail_cyc = r_ff_cyc;

endmodule
`default_nettype wire

// File: tb/tb_logic_relation_checker.sv
`default_nettype none
// ============================================================================
// tb_logic_relation_checker : random windows vs. a rule-level reference model
// Rev 1.0
// ============================================================================
module tb_logic_relation_checker;
   localparam int NCH   = 4;
   localparam int WIN_W = 8;
   localparam int CWA   = 16;
   localparam int CWB   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             start_d = 1'b0;
   logic [WIN_W-1:0] wl_d    = '0;
   logic [2*NCH-1:0] mode_d  = '0;
   logic [NCH-1:0]   en_d    = '0;
   logic [NCH-1:0]   a_d     = '0;
   logic [NCH-1:0]   b_d     = '0;

   logic_relation_checker_if #(.NCH(NCH), .CNT_W(CWA), .WIN_W(WIN_W)) ifa ();
   logic_relation_checker_if #(.NCH(NCH), .CNT_W(CWB), .WIN_W(WIN_W)) ifb ();

   assign ifa.start = start_d;  assign ifb.start = start_d;
   assign ifa.win_len = wl_d;   assign ifb.win_len = wl_d;
   assign ifa.mode = mode_d;    assign ifb.mode = mode_d;
   assign ifa.ch_en = en_d;     assign ifb.ch_en = en_d;
   assign ifa.a = a_d;          assign ifb.a = a_d;
   assign ifa.b = b_d;          assign ifb.b = b_d;

   logic_relation_checker #(.NCH(NCH), .CNT_W(CWA), .WIN_W(WIN_W)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   logic_relation_checker #(.NCH(NCH), .CNT_W(CWB), .WIN_W(WIN_W)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   int n_chk = 0;
   int n_ok  = 0;

   int           exp_pass [NCH];
   int           exp_fail [NCH];
   logic [NCH-1:0] exp_sticky;
   logic         exp_vld;
   int           exp_ch;
   int           exp_cyc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_ok++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   function automatic bit rel(input logic [1:0] m, input bit x, input bit y);
      case (m)
         2'd0:    return x && y;
         2'd1:    return x || y;
         2'd2:    return x != y;
         default: return x == y;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) begin
         exp_pass[i] = 0;
         exp_fail[i] = 0;
      end
      exp_sticky = '0;
      exp_vld    = 1'b0;
      exp_ch     = 0;
      exp_cyc    = 0;
   endtask

   task automatic model_update(input int k);
      bit any;
      any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (en_d[i]) begin
            if (rel(mode_d[2*i +: 2], a_d[i], b_d[i])) exp_pass[i]++;
            else begin
               exp_fail[i]++;
               exp_sticky[i] = 1'b1;
               if (!any && !exp_vld) begin
                  any    = 1'b1;
                  exp_ch = i;
               end
            end
         end
      end
      if (any) begin
         exp_vld = 1'b1;
         exp_cyc = k;
      end
   endtask

   task automatic gen(input int pat, input int k);
      case (pat)
         1: begin mode_d = '0; en_d = '1; a_d = '1; b_d = '1; end
         2: begin
            mode_d = 8'hE4; en_d = '1;
            a_d = (k < 2) ? 4'hF : 4'h0;
            b_d = (k < 1) ? 4'hF : 4'h0;
         end
         3: begin mode_d = '0; en_d = 4'b0101; a_d = '0; b_d = '0; end
         default: begin
            mode_d = (2*NCH)'($urandom());
            en_d   = NCH'($urandom());
            a_d    = NCH'($urandom());
            b_d    = NCH'($urandom());
         end
      endcase
   endtask

   task automatic chk_state(input string ph, input logic busy_e, input logic done_e);
      chk({ph, " busyA"}, 32'(ifa.busy), 32'(busy_e));
      chk({ph, " doneA"}, 32'(ifa.done), 32'(done_e));
      chk({ph, " busyB"}, 32'(ifb.busy), 32'(busy_e));
      chk({ph, " doneB"}, 32'(ifb.done), 32'(done_e));
   endtask

   task automatic check_results(input string ph);
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("%s passA%0d", ph, i), 32'(ifa.pass_cnt[i*CWA +: CWA]), sat(exp_pass[i], CWA));
         chk($sformatf("%s failA%0d", ph, i), 32'(ifa.fail_cnt[i*CWA +: CWA]), sat(exp_fail[i], CWA));
         chk($sformatf("%s passB%0d", ph, i), 32'(ifb.pass_cnt[i*CWB +: CWB]), sat(exp_pass[i], CWB));
         chk($sformatf("%s failB%0d", ph, i), 32'(ifb.fail_cnt[i*CWB +: CWB]), sat(exp_fail[i], CWB));
      end
      chk({ph, " stickyA"}, 32'(ifa.fail_sticky), 32'(exp_sticky));
      chk({ph, " stickyB"}, 32'(ifb.fail_sticky), 32'(exp_sticky));
      chk({ph, " ff_vld"},  32'(ifa.first_fail_vld), 32'(exp_vld));
      chk({ph, " ff_ch"},   32'(ifa.first_fail_ch),  exp_ch);
      chk({ph, " ff_cyc"},  32'(ifa.first_fail_cyc), exp_cyc);
      chk({ph, " ff_vldB"}, 32'(ifb.first_fail_vld), 32'(exp_vld));
   endtask

   // rst_at >= 0 asserts reset on the sample edge where idx == rst_at
   task automatic run_window(input int wl, input int pat, input int rst_at);
      string ph;
      ph = $sformatf("w%0d/p%0d", wl, pat);
      model_clear();
      start_d = 1'b1;
      wl_d    = wl[WIN_W-1:0];
      gen(0, 0);
      @(posedge clk); #1;
      start_d = 1'b0;
      for (int k = 0; k < wl; k++) begin
         chk_state({ph, " run"}, 1'b1, 1'b0);
         if (k == rst_at) begin
            start_d = 1'b0;
            rst_n   = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_clear();
            chk_state({ph, " rst"}, 1'b0, 1'b0);
            check_results({ph, " rst"});
            return;
         end
         gen(pat, k);
         start_d = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         model_update(k);
      end
      start_d = 1'($urandom_range(0, 1));
      chk_state({ph, " done"}, 1'b1, 1'b1);
      @(posedge clk); #1;
      start_d = 1'b0;
      chk_state({ph, " idle"}, 1'b0, 1'b0);
      check_results(ph);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_clear();
      chk_state("reset", 1'b0, 1'b0);
      check_results("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_window(4, 1, -1);
      run_window(3, 2, -1);
      run_window(3, 3, -1);
      run_window(6, 1, -1);
      run_window(0, 0, -1);
      run_window(8, 0, 2);
      run_window(8, 0, -1);
      for (int t = 0; t < 40; t++) begin
         run_window(int'($urandom_range(0, 24)), 0, -1);
      end
      run_window(255, 0, -1);

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
